// File: rtl/rad4_exact_div.sv
// Sequential radix-4 restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor,
// two quotient bits per cycle, valid/ready on both sides.
module rad4_exact_div #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_by_zero,
  output logic               overflow
);
  localparam int ITERS = WIDTH / 2;
  localparam int CW    = (ITERS > 1) ? $clog2(ITERS) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   dvsr;
  logic [WIDTH+1:0]   d3;
  logic [WIDTH-1:0]   dvd_lo;
  logic [CW-1:0]      cnt;

  logic               accept, zero_div, hi_ovf, last_iter;
  logic [WIDTH+1:0]   s, d1, d2, sub;
  logic [1:0]         q;
  logic [WIDTH-1:0]   r_next;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign zero_div  = (divisor == '0);
  assign hi_ovf    = (dividend[2*WIDTH-1:WIDTH] >= divisor);
  assign last_iter = (cnt == CW'(ITERS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (zero_div || hi_ovf) ? DONE : CALC;
      CALC:    if (last_iter) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Partial remainder lives in the remainder register while calculating;
  // it stays below the divisor, so the shifted window fits WIDTH+2 bits.
  always_comb begin
    s  = {remainder, dvd_lo[WIDTH-1:WIDTH-2]};
    d1 = {2'b00, dvsr};
    d2 = {1'b0, dvsr, 1'b0};
    if (s >= d3) begin
      q = 2'd3; sub = d3;
    end else if (s >= d2) begin
      q = 2'd2; sub = d2;
    end else if (s >= d1) begin
      q = 2'd1; sub = d1;
    end else begin
      q = 2'd0; sub = '0;
    end
    r_next = WIDTH'(s - sub);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      dvsr        <= '0;
      d3          <= '0;
      dvd_lo      <= '0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          div_by_zero <= 1'b0;
          overflow    <= 1'b0;
          dvsr        <= divisor;
          d3          <= {2'b00, divisor} + {1'b0, divisor, 1'b0};
          cnt         <= '0;
          dvd_lo      <= dividend[WIDTH-1:0];
          if (zero_div) begin
            div_by_zero <= 1'b1;
            quotient    <= '1;
            remainder   <= dividend[WIDTH-1:0];
          end else if (hi_ovf) begin
            overflow    <= 1'b1;
            quotient    <= '1;
            remainder   <= dividend[WIDTH-1:0];
          end else begin
            quotient    <= '0;
            remainder   <= dividend[2*WIDTH-1:WIDTH];
          end
        end
        CALC: begin
          remainder <= r_next;
          quotient  <= {quotient[WIDTH-3:0], q};
          dvd_lo    <= {dvd_lo[WIDTH-3:0], 2'b00};
          cnt       <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_rad4_exact_div.sv
// Randomized scoreboard bench for rad4_exact_div against a plain-arithmetic division model.
module tb_rad4_exact_div;
  localparam int W     = 16;
  localparam int ITERS = W / 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [2*W-1:0]  dividend = '0;
  logic [W-1:0]    divisor = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [W-1:0]    quotient, remainder;
  logic            div_by_zero, overflow;

  rad4_exact_div #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
    .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0]   q, r;
    logic           dbz, ovf;
    logic [2*W-1:0] dvd;
    logic [W-1:0]   dvs;
    int             acc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0, n_bad = 0;
  bit   bp = 1'b0, hold = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  function automatic exp_t model(input logic [2*W-1:0] a, input logic [W-1:0] b, input int acc);
    exp_t e;
    longint unsigned qq;
    e.dvd = a; e.dvs = b; e.acc = acc;
    e.dbz = 1'b0; e.ovf = 1'b0;
    if (b == 0) begin
      e.dbz = 1'b1; e.q = '1; e.r = a[W-1:0];
    end else begin
      qq = longint'(a) / longint'(b);
      if (qq > 64'hFFFF) begin
        e.ovf = 1'b1; e.q = '1; e.r = a[W-1:0];
      end else begin
        e.q = W'(qq);
        e.r = W'(longint'(a) % longint'(b));
      end
    end
    return e;
  endfunction

  // Present an operation and hold it until the accept edge; expectation queued on acceptance.
  task automatic do_op(input logic [2*W-1:0] a, input logic [W-1:0] b);
    int  w = 0;
    bit  done = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; dividend = a; divisor = b;
    while (!done && w < 200) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(model(a, b, cyc));
        done = 1'b1;
      end
      w++;
    end
    if (!done) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic rand_op();
    logic [2*W-1:0] a;
    logic [W-1:0]   b, qv, rv;
    logic [63:0]    t;
    int             m = $urandom_range(0, 9);
    a = $urandom;
    qv = W'($urandom);
    case (m)
      0: b = '0;
      1: b = W'($urandom);
      2: b = W'($urandom_range(1, 3));
      3: b = 16'hFFFF;
      default: b = W'($urandom_range(1, 65535));
    endcase
    if (m >= 2) begin
      rv = W'($urandom % b);
      t  = 64'(qv) * 64'(b) + 64'(rv);
      a  = t[2*W-1:0];
    end
    do_op(a, b);
  endtask

  // Downstream backpressure, unless the stimulus holds out_ready itself.
  initial forever begin
    @(posedge clk); #1;
    if (!hold) out_ready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // Monitor: compares whatever the DUT presents against the head of the scoreboard.
  initial begin
    bit          seen = 1'b0, have_prev = 1'b0;
    logic [W-1:0] pq = '0, pr = '0;
    logic         pz = 1'b0, po = 1'b0;
    logic [63:0]  prod;
    exp_t         e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        seen = 1'b0; have_prev = 1'b0;
      end else if (!out_valid) begin
        if (have_prev) chk("valid_dropped", 64'd0, 64'd1);
        have_prev = 1'b0;
      end else if (sb.size() == 0) begin
        chk("spurious_out_valid", 64'd1, 64'd0);
      end else begin
        e = sb[0];
        if (!seen) begin
          chk("latency", 64'(cyc - e.acc), (e.dbz || e.ovf) ? 64'd1 : 64'(ITERS + 1));
          seen = 1'b1;
        end
        if (have_prev) begin
          chk("hold_quotient", 64'(quotient), 64'(pq));
          chk("hold_remainder", 64'(remainder), 64'(pr));
          chk("hold_flags", {62'd0, div_by_zero, overflow}, {62'd0, pz, po});
        end
        chk("in_ready_busy", 64'(in_ready), 64'd0);
        if (out_ready) begin
          chk("quotient", 64'(quotient), 64'(e.q));
          chk("remainder", 64'(remainder), 64'(e.r));
          chk("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
          chk("overflow", 64'(overflow), 64'(e.ovf));
          if (!e.dbz && !e.ovf) begin
            prod = 64'(quotient) * 64'(e.dvs) + 64'(remainder);
            chk("identity", prod, 64'(e.dvd));
            chk("rem_lt_div", 64'(remainder < e.dvs), 64'd1);
          end
          void'(sb.pop_front());
          seen = 1'b0; have_prev = 1'b0;
        end else begin
          have_prev = 1'b1;
          pq = quotient; pr = remainder; pz = div_by_zero; po = overflow;
        end
      end
    end
  end

  task automatic chk_reset_state(input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_quotient"}, 64'(quotient), 64'd0);
    chk({tag, "_remainder"}, 64'(remainder), 64'd0);
    chk({tag, "_flags"}, {62'd0, div_by_zero, overflow}, 64'd0);
  endtask

  task automatic drain();
    int w = 0;
    while (sb.size() != 0 && w < 500) begin
      @(negedge clk); w++;
    end
    chk("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int w;
    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // Directed: normal, max quotient, divide by zero, overflow
    do_op(32'd100, 16'd7);
    do_op(32'hFFFE0001, 16'hFFFF);
    do_op(32'd123, 16'd0);
    do_op(32'h00010000, 16'd1);
    drain();

    // Backpressure in DONE while in_valid is asserted: nothing else may be accepted
    @(posedge clk); #1;
    hold = 1'b1; out_ready = 1'b0;
    do_op(32'd1000, 16'd9);
    w = 0;
    while (!out_valid && w < 50) begin
      @(negedge clk); w++;
    end
    chk("t5_reach_done", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b1; dividend = 32'd77; divisor = 16'd5;
    repeat (5) begin
      @(negedge clk);
      chk("t5_in_ready_low", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1; hold = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t5_idle_after_handshake", 64'(in_ready), 64'd1);
    do_op(32'h0000ABCD, 16'h0123);
    drain();

    // Reset in the middle of a calculation discards the operation
    do_op(32'h12345678, 16'h4321);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    chk_reset_state("midreset");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("midreset_idle", 64'(in_ready), 64'd1);

    // Random operands with random downstream backpressure
    bp = 1'b1;
    for (int i = 0; i < 2500; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      rand_op();
    end
    drain();
    bp = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
